// File: rtl/cronometro_ctrl.sv
// Stopwatch control: key conditioning, run/pause/clear/recall FSM, 100 Hz tick, lap buffer.
// Ports: CLOCK_50/reset (sync, high); key_*_n, sel in; cnt_sec/cnt_cs in; tick/clr/ld/ld_sec/ld_cs/state/lap_cnt/lap_full out. Macro: CRONO_DEBOUNCE_EN.
module cronometro_ctrl #(
  parameter int CLK_DIV      = 500000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LAPS         = 3
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        key_start_n,
  input  logic                        key_clr_n,
  input  logic                        key_lap_n,
  input  logic [LAPS-1:0]             sel,
  input  logic [5:0]                  cnt_sec,
  input  logic [6:0]                  cnt_cs,
  output logic                        tick,
  output logic                        clr,
  output logic                        ld,
  output logic [5:0]                  ld_sec,
  output logic [6:0]                  ld_cs,
  output logic [1:0]                  state,
  output logic [$clog2(LAPS+1)-1:0]   lap_cnt,
  output logic                        lap_full
);

  localparam int CW  = $clog2(LAPS + 1);
  localparam int PW  = $clog2(LAPS);
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_MAX = DVW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  PTR_MAX = PW'(LAPS - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    RECALL = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0] keys;
  logic [2:0] k1_q, k2_q;
  logic [2:0] flt_q, flt_d;
  logic [2:0] ev_q, ev_d;
  logic [LAPS-1:0] sel1_q, sel2_q;

`ifdef CRONO_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYC - 1);
  logic [DBW-1:0] dcnt_q [3];
  logic [DBW-1:0] dcnt_d [3];
`endif

  logic [DVW-1:0] div_q, div_d;
  logic [12:0]    lap_q [LAPS];
  logic [12:0]    lap_d [LAPS];
  logic [PW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [12:0]    snap_q, snap_d;
  logic [PW-1:0]  cur_q, cur_d;
  logic           tick_q, tick_d;
  logic           clr_q, clr_d;
  logic           ld_q, ld_d;
  logic [12:0]    ldv_q, ldv_d;

  logic          e_start, e_clr, e_lap;
  logic          sel_any;
  logic [PW-1:0] sel_idx;
  logic          do_clr;

  assign keys = {key_lap_n, key_clr_n, key_start_n};

  // Filtered level flips only after DEBOUNCE_CYC consecutive
  // differing samples; a flip to 0 is the press event.
  always_comb begin : key_comb
    flt_d = flt_q;
    ev_d  = '0;
`ifdef CRONO_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (k2_q[i] != flt_q[i]) begin
        if (dcnt_q[i] == DB_MAX) begin
          flt_d[i] = k2_q[i];
          ev_d[i]  = ~k2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
`else
    flt_d = k2_q;
    ev_d  = flt_q & ~k2_q;
`endif
  end

  // Priority resolution: clr > start > lap.
  assign e_clr   = ev_q[1];
  assign e_start = ev_q[0] & ~ev_q[1];
  assign e_lap   = ev_q[2] & ~ev_q[1] & ~ev_q[0];

  assign sel_any = |sel2_q;

  always_comb begin : sel_pick
    sel_idx = '0;
    for (int i = LAPS - 1; i >= 0; i--) begin
      if (sel2_q[i]) sel_idx = PW'(i);
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (e_start) state_d = RUN;
      RUN:    if (e_start) state_d = PAUSE;
      PAUSE: begin
        if (e_clr)        state_d = IDLE;
        else if (e_start) state_d = RUN;
        else if (sel_any) state_d = RECALL;
      end
      RECALL: begin
        if (e_clr)         state_d = IDLE;
        else if (!sel_any) state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : out_comb
    div_d  = div_q;
    tick_d = 1'b0;
    clr_d  = 1'b0;
    ld_d   = 1'b0;
    ldv_d  = ldv_q;
    snap_d = snap_q;
    cur_d  = cur_q;
    lap_d  = lap_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    do_clr = 1'b0;
    unique case (state_q)
      IDLE: div_d = '0;
      RUN: begin
        tick_d = (div_q == DIV_MAX);
        div_d  = tick_d ? '0 : div_q + 1'b1;
        if (e_lap) begin
          lap_d[wr_q] = {cnt_sec, cnt_cs};
          wr_d = (wr_q == PTR_MAX) ? '0 : wr_q + 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      PAUSE: begin
        if (e_clr) begin
          do_clr = 1'b1;
        end else if (!e_start && sel_any) begin
          snap_d = {cnt_sec, cnt_cs};
          ld_d   = 1'b1;
          ldv_d  = lap_q[sel_idx];
          cur_d  = sel_idx;
        end
      end
      RECALL: begin
        if (e_clr) begin
          do_clr = 1'b1;
        end else if (!sel_any) begin
          ld_d  = 1'b1;
          ldv_d = snap_q;
        end else if (sel_idx != cur_q) begin
          ld_d  = 1'b1;
          ldv_d = lap_q[sel_idx];
          cur_d = sel_idx;
        end
      end
      default: ;
    endcase
    if (do_clr) begin
      clr_d = 1'b1;
      div_d = '0;
      wr_d  = '0;
      cnt_d = '0;
      for (int i = 0; i < LAPS; i++) lap_d[i] = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin : regs
    if (reset) begin
      state_q <= IDLE;
      k1_q    <= '1;
      k2_q    <= '1;
      flt_q   <= '1;
      ev_q    <= '0;
      sel1_q  <= '0;
      sel2_q  <= '0;
`ifdef CRONO_DEBOUNCE_EN
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
`endif
      div_q   <= '0;
      for (int i = 0; i < LAPS; i++) lap_q[i] <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      cur_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      ldv_q   <= '0;
    end else begin
      state_q <= state_d;
      k1_q    <= keys;
      k2_q    <= k1_q;
      flt_q   <= flt_d;
      ev_q    <= ev_d;
      sel1_q  <= sel;
      sel2_q  <= sel1_q;
`ifdef CRONO_DEBOUNCE_EN
      dcnt_q  <= dcnt_d;
`endif
      div_q   <= div_d;
      lap_q   <= lap_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      cur_q   <= cur_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      ld_q    <= ld_d;
      ldv_q   <= ldv_d;
    end
  end

  assign tick     = tick_q;
  assign clr      = clr_q;
  assign ld       = ld_q;
  assign ld_sec   = ldv_q[12:7];
  assign ld_cs    = ldv_q[6:0];
  assign state    = state_q;
  assign lap_cnt  = cnt_q;
  assign lap_full = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl: vector table plus glitch and reset sequences.
// Tick timing is checked every cycle against a small divider model.
module tb_cronometro_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 8;
  localparam int LAPS    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       k_start = 1'b1;
  logic       k_clr = 1'b1;
  logic       k_lap = 1'b1;
  logic [2:0] sel = '0;
  logic [5:0] sec = '0;
  logic [6:0] cs = '0;
  logic       tick, clr, ld;
  logic [5:0] ld_sec;
  logic [6:0] ld_cs;
  logic [1:0] st;
  logic [1:0] lap_cnt;
  logic       lap_full;

  always #5 clk = ~clk;

  cronometro_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYC(DEB),
    .LAPS(LAPS)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .key_start_n(k_start),
    .key_clr_n(k_clr),
    .key_lap_n(k_lap),
    .sel(sel),
    .cnt_sec(sec),
    .cnt_cs(cs),
    .tick(tick),
    .clr(clr),
    .ld(ld),
    .ld_sec(ld_sec),
    .ld_cs(ld_cs),
    .state(st),
    .lap_cnt(lap_cnt),
    .lap_full(lap_full)
  );

  int total = 0;
  int bad = 0;

  int          mdiv = 0;
  logic        exp_tk = 1'b0;
  logic        prev_ld = 1'b0;
  logic        prev_clr = 1'b0;
  int          ld_n = 0;
  int          clr_n = 0;
  logic [12:0] ld_cap = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock; samples at the falling edge and runs the tick model.
  task automatic cyc();
    @(negedge clk);
    chk("tick", {31'd0, tick}, {31'd0, exp_tk});
    if (ld) begin
      chk("ld_width", {31'd0, prev_ld}, 32'd0);
      ld_n++;
      ld_cap = {ld_sec, ld_cs};
    end
    if (clr) begin
      chk("clr_width", {31'd0, prev_clr}, 32'd0);
      clr_n++;
    end
    prev_ld  = ld;
    prev_clr = clr;
    if (rst) begin
      exp_tk = 1'b0;
      mdiv   = 0;
    end else if (st == 2'd1) begin
      exp_tk = (mdiv == CLK_DIV - 1);
      mdiv   = (mdiv + 1) % CLK_DIV;
    end else begin
      exp_tk = 1'b0;
      if (st == 2'd0) mdiv = 0;
    end
  endtask

  // key: 0 none, 1 start, 2 clr, 3 lap, 4 start+clr
  task automatic press(input int key);
    if (key == 0) begin
      repeat (8) cyc();
    end else begin
      k_start = !(key == 1 || key == 4);
      k_clr   = !(key == 2 || key == 4);
      k_lap   = !(key == 3);
      repeat (14) cyc();
      k_start = 1'b1;
      k_clr   = 1'b1;
      k_lap   = 1'b1;
      repeat (14) cyc();
    end
  endtask

  typedef struct {
    int          key;
    logic [2:0]  sel;
    logic [5:0]  sec;
    logic [6:0]  cs;
    logic [1:0]  st;
    logic [1:0]  cnt;
    logic        full;
    int          dld;
    logic [12:0] ldv;
    int          dclr;
  } vec_t;

  function automatic vec_t mk(input int key, input logic [2:0] s,
                              input logic [5:0] se, input logic [6:0] c,
                              input logic [1:0] xs, input logic [1:0] xc,
                              input logic xf, input int xl,
                              input logic [12:0] xv, input int xclr);
    vec_t v;
    v.key = key; v.sel = s; v.sec = se; v.cs = c;
    v.st = xs; v.cnt = xc; v.full = xf;
    v.dld = xl; v.ldv = xv; v.dclr = xclr;
    return v;
  endfunction

  vec_t vt [23];

  initial begin
    int l0, c0;
    logic exp_glitch;

    vt[0]  = mk(1, 3'b000, 6'd0, 7'd1,  2'd1, 2'd0, 1'b0, 0, 13'd0, 0);
    vt[1]  = mk(3, 3'b000, 6'd0, 7'd1,  2'd1, 2'd1, 1'b0, 0, 13'd0, 0);
    vt[2]  = mk(3, 3'b000, 6'd0, 7'd2,  2'd1, 2'd2, 1'b0, 0, 13'd0, 0);
    vt[3]  = mk(3, 3'b000, 6'd0, 7'd3,  2'd1, 2'd3, 1'b1, 0, 13'd0, 0);
    vt[4]  = mk(3, 3'b000, 6'd0, 7'd4,  2'd1, 2'd3, 1'b1, 0, 13'd0, 0);
    vt[5]  = mk(1, 3'b000, 6'd0, 7'd4,  2'd2, 2'd3, 1'b1, 0, 13'd0, 0);
    vt[6]  = mk(1, 3'b000, 6'd0, 7'd4,  2'd1, 2'd3, 1'b1, 0, 13'd0, 0);
    vt[7]  = mk(1, 3'b000, 6'd0, 7'd4,  2'd2, 2'd3, 1'b1, 0, 13'd0, 0);
    vt[8]  = mk(0, 3'b001, 6'd1, 7'd50, 2'd3, 2'd3, 1'b1, 1,
                {6'd0, 7'd4}, 0);
    vt[9]  = mk(0, 3'b010, 6'd1, 7'd50, 2'd3, 2'd3, 1'b1, 1,
                {6'd0, 7'd2}, 0);
    vt[10] = mk(0, 3'b000, 6'd1, 7'd50, 2'd2, 2'd3, 1'b1, 1,
                {6'd1, 7'd50}, 0);
    vt[11] = mk(4, 3'b000, 6'd1, 7'd50, 2'd0, 2'd0, 1'b0, 0, 13'd0, 1);
    vt[12] = mk(0, 3'b100, 6'd1, 7'd50, 2'd0, 2'd0, 1'b0, 0, 13'd0, 0);
    vt[13] = mk(1, 3'b000, 6'd1, 7'd50, 2'd1, 2'd0, 1'b0, 0, 13'd0, 0);
    vt[14] = mk(0, 3'b100, 6'd1, 7'd50, 2'd1, 2'd0, 1'b0, 0, 13'd0, 0);
    vt[15] = mk(3, 3'b000, 6'd0, 7'd7,  2'd1, 2'd1, 1'b0, 0, 13'd0, 0);
    vt[16] = mk(1, 3'b000, 6'd2, 7'd3,  2'd2, 2'd1, 1'b0, 0, 13'd0, 0);
    vt[17] = mk(0, 3'b010, 6'd2, 7'd3,  2'd3, 2'd1, 1'b0, 1,
                {6'd0, 7'd0}, 0);
    vt[18] = mk(0, 3'b011, 6'd2, 7'd3,  2'd3, 2'd1, 1'b0, 1,
                {6'd0, 7'd7}, 0);
    vt[19] = mk(0, 3'b000, 6'd2, 7'd3,  2'd2, 2'd1, 1'b0, 1,
                {6'd2, 7'd3}, 0);
    vt[20] = mk(0, 3'b001, 6'd2, 7'd3,  2'd3, 2'd1, 1'b0, 1,
                {6'd0, 7'd7}, 0);
    vt[21] = mk(2, 3'b001, 6'd2, 7'd3,  2'd0, 2'd0, 1'b0, 0, 13'd0, 1);
    vt[22] = mk(0, 3'b000, 6'd2, 7'd3,  2'd0, 2'd0, 1'b0, 0, 13'd0, 0);

    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_clr", {31'd0, clr}, 32'd0);
    chk("rst_ld", {31'd0, ld}, 32'd0);
    chk("rst_lap_cnt", {30'd0, lap_cnt}, 32'd0);
    chk("rst_lap_full", {31'd0, lap_full}, 32'd0);
    chk("rst_ld_val", {19'd0, ld_sec, ld_cs}, 32'd0);
    rst = 1'b0;
    repeat (4) cyc();

    for (int i = 0; i < 23; i++) begin
      l0 = ld_n;
      c0 = clr_n;
      sel = vt[i].sel;
      sec = vt[i].sec;
      cs  = vt[i].cs;
      press(vt[i].key);
      chk($sformatf("v%0d_state", i), {30'd0, st}, {30'd0, vt[i].st});
      chk($sformatf("v%0d_lap_cnt", i), {30'd0, lap_cnt},
          {30'd0, vt[i].cnt});
      chk($sformatf("v%0d_lap_full", i), {31'd0, lap_full},
          {31'd0, vt[i].full});
      chk($sformatf("v%0d_ld_n", i), ld_n - l0, vt[i].dld);
      chk($sformatf("v%0d_clr_n", i), clr_n - c0, vt[i].dclr);
      if (vt[i].dld > 0) begin
        chk($sformatf("v%0d_ld_val", i), {19'd0, ld_cap},
            {19'd0, vt[i].ldv});
        chk($sformatf("v%0d_ld_hold", i), {19'd0, ld_sec, ld_cs},
            {19'd0, vt[i].ldv});
      end
    end

    // Short glitch on the lap key while running.
    press(1);
    chk("run_again", {30'd0, st}, 32'd1);
`ifdef CRONO_DEBOUNCE_EN
    exp_glitch = 1'b0;
`else
    exp_glitch = 1'b1;
`endif
    k_lap = 1'b0;
    repeat (5) cyc();
    k_lap = 1'b1;
    repeat (20) cyc();
    chk("glitch_lap_cnt", {30'd0, lap_cnt}, {31'd0, exp_glitch});

    // Reset in the middle of a start press.
    k_start = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    k_start = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (20) cyc();
    chk("midrst_state", {30'd0, st}, 32'd0);
    chk("midrst_lap_cnt", {30'd0, lap_cnt}, 32'd0);
    chk("midrst_ld_val", {19'd0, ld_sec, ld_cs}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Control sequencer for the stopwatch seconds/centiseconds datapath. Conditions the three push-buttons, runs the run/pause/clear/recall state machine, generates the 100 Hz count-enable tick, and owns a circular lap buffer whose entries it loads back into the datapath on request. The datapath counters and display decoding stay outside the block; this block only tells them when to count, clear or load.

## Interface
Parameters:
- CLK_DIV, 500000, CLOCK_50 cycles per centisecond tick (50 MHz / 100 Hz).
- DEBOUNCE_CYC, 1000000, stable-level cycles required before a key is accepted (20 ms).
- LAPS, 3, lap buffer depth (2..8).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- key_start_n  in  1  start/pause button, active-low, asynchronous.
- key_clr_n  in  1  clear button, active-low, asynchronous.
- key_lap_n  in  1  lap-store button, active-low, asynchronous.
- sel  in  LAPS  recall request, one per slot, asynchronous level (switches).
- cnt_sec  in  6  datapath seconds, 0..59.
- cnt_cs  in  7  datapath centiseconds, 0..99.
- tick  out  1  one-cycle count enable to datapath.
- clr  out  1  one-cycle datapath clear.
- ld  out  1  one-cycle datapath load strobe.
- ld_sec  out  6  load value, seconds.
- ld_cs  out  7  load value, centiseconds.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, RECALL=3.
- lap_cnt  out  $clog2(LAPS+1)  stored laps, saturating at LAPS.
- lap_full  out  1  lap_cnt == LAPS.

## Operation
- Each key: 2-flop synchronizer, debounce filter, falling-edge detector giving a one-cycle event (ev_start, ev_clr, ev_lap). sel passes through a 2-flop synchronizer only.
- Lap entry is 13 bits {sec[5:0], cs[6:0]}; write pointer wraps LAPS-1 -> 0, overwriting the oldest entry.
- Event priority in one cycle: clr > start > lap; lower-priority events in the same cycle are dropped.
- IDLE: divider held at 0. ev_start -> RUN. ev_lap, ev_clr, sel ignored.
- RUN: divider counts 0..CLK_DIV-1; tick=1 in the cycle divider==CLK_DIV-1, then divider wraps to 0. ev_lap writes {cnt_sec,cnt_cs} (sampled that cycle) to lap[wr_ptr], advances wr_ptr, increments lap_cnt (saturating). ev_start -> PAUSE. ev_clr and sel ignored.
- PAUSE: divider holds its value (partial centisecond preserved). ev_start -> RUN. ev_clr -> clr pulse, divider=0, lap buffer zeroed, wr_ptr=0, lap_cnt=0, -> IDLE. sel!=0 -> snapshot {cnt_sec,cnt_cs}, ld pulse with lap[lowest set bit of sel], -> RECALL.
- RECALL: tick=0. Change to a different lowest set bit re-issues ld with that slot. sel==0 -> ld pulse with snapshot, -> PAUSE. ev_start, ev_lap ignored; ev_clr behaves as in PAUSE (no restore ld).
- Recall of a never-written slot loads 0:00.
- ld_sec/ld_cs hold their last value between strobes.

## Timing
- Reset: state=IDLE, tick=0, clr=0, ld=0, ld_sec=0, ld_cs=0, lap_cnt=0, lap_full=0, divider=0, wr_ptr=0, all lap entries 0, synchronizers/filters at released (1) level.
- Key latency: 2 sync cycles + DEBOUNCE_CYC stable cycles, then event pulse; state/outputs update on the clock edge sampling the event (state visible 1 cycle after event).
- First tick after IDLE->RUN: CLK_DIV cycles after state reads RUN. After PAUSE->RUN: CLK_DIV minus cycles already counted.
- clr, ld, tick are exactly one cycle wide; ld_sec/ld_cs valid in the same cycle as ld.
- reset mid-operation overrides everything on the next edge, including an in-progress debounce.

## Configuration
- CRONO_DEBOUNCE_EN defined: debounce filter per key as above.
- Not defined: filter removed; event generated from the synchronized falling edge (2-cycle latency), DEBOUNCE_CYC unused.

## Test plan
Bench uses CLK_DIV=4, DEBOUNCE_CYC=8, LAPS=3, CRONO_DEBOUNCE_EN defined unless noted.
- Reset asserted 3 cycles -> state=0, tick/clr/ld=0, lap_cnt=0, lap_full=0.
- Press start 20 cycles -> state=1, tick every 4th cycle; press again after 2 divider counts -> state=2, no tick; press again -> next tick exactly 2 cycles after RUN.
- In RUN, 4 lap presses with cnt={0,1},{0,2},{0,3},{0,4} -> lap_cnt=3, lap_full=1; pause, sel=001 -> ld with {0,4}, state=3.
- In RECALL (snapshot {1,50}), sel 001->010 -> ld {0,2}; sel->000 -> ld {1,50}, state=2.
- In PAUSE, start and clr released low in same cycle -> clr pulse, state=0, lap_cnt=0; then sel=100 ignored.
- 5-cycle low glitch on key_lap_n -> no event; with CRONO_DEBOUNCE_EN undefined same glitch -> lap stored.
